// File: rtl/gmii_rx_pkg.sv
// Shared constants, state encoding and field widths for the GMII receive path.
package gmii_rx_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  // Register value left after running a good frame plus its FCS through crc32_d8
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;

  localparam int STAT_LEN_W = 16;
  localparam int CNT_W      = 32;

  // Bytes held back before output: the trailing FCS when stripping, else one pipeline stage
  localparam int HOLD_DEPTH_STRIP = 5;
  localparam int HOLD_DEPTH_PASS  = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_t;

  // Frame length counter that sticks at all-ones instead of wrapping
  function automatic logic [STAT_LEN_W-1:0] len_inc(input logic [STAT_LEN_W-1:0] len);
    return (len == '1) ? len : len + 1'b1;
  endfunction

endpackage

// File: rtl/gmii_rx_framer_crc32_d8.sv
// Combinational CRC-32 step over one byte, data taken LSB first.
// The register is kept in non-reflected bit order (shift left, poly 0x04C11DB7),
// which is the bit-mirror of the usual reflected software form; a good frame
// including its FCS therefore leaves CRC_RESIDUE in the register.
module crc32_d8 (
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] c_work;

  // Eight serial LFSR steps unrolled into one combinational update
  always_comb begin
    c_work = crc;
    for (int i = 0; i < 8; i++) begin
      if (c_work[31] ^ data[i]) begin
        c_work = {c_work[30:0], 1'b0} ^ 32'h04C1_1DB7;
      end else begin
        c_work = {c_work[30:0], 1'b0};
      end
    end
    crc_next = c_work;
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, optionally strips FCS, checks
// CRC-32, length and rx_er, and keeps wrapping per-outcome frame counters.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// IDLE     | between frames, waiting for rx_dv
// PREAMBLE | counting 0x55 bytes, waiting for SFD
// DATA     | frame body: CRC, length, hold line, byte output
// DROP     | discarding until rx_dv falls (also the post-reset state)
module gmii_rx_framer
  import gmii_rx_pkg::*;
#(
  parameter int STRIP_FCS    = 1,
  parameter int MIN_LEN      = 64,
  parameter int MAX_LEN      = 1522,
  parameter int MAX_PREAMBLE = 7
) (
  input  logic                  rx_clk,
  input  logic                  reset,
  input  logic [7:0]            gmii_rxd,
  input  logic                  gmii_rx_dv,
  input  logic                  gmii_rx_er,
  output logic [7:0]            data_out,
  output logic                  data_valid,
  output logic                  data_sof,
  output logic                  data_eof,
  output logic                  stat_valid,
  output logic [STAT_LEN_W-1:0] stat_len,
  output logic                  stat_crc_err,
  output logic                  stat_len_err,
  output logic                  stat_gmii_err,
  output logic [CNT_W-1:0]      cnt_good,
  output logic [CNT_W-1:0]      cnt_bad,
  output logic [CNT_W-1:0]      cnt_drop
);

  localparam int HOLD_D = (STRIP_FCS != 0) ? HOLD_DEPTH_STRIP : HOLD_DEPTH_PASS;
  localparam int PRE_W  = $clog2(MAX_PREAMBLE + 2);

  rx_state_t             state;
  logic [PRE_W-1:0]      pre_cnt;
  logic [31:0]           crc;
  logic [31:0]           crc_next;
  logic [STAT_LEN_W-1:0] len;
  logic                  gmii_err;
  logic                  sof_pend;
  // DROP reached through reset must not be counted as a dropped frame
  logic                  from_reset;
  logic [7:0]            hold [HOLD_D];

  logic hold_full;
  logic crc_err_now;
  logic len_err_now;
  logic any_err_now;

  crc32_d8 u_crc (
    .crc      (crc),
    .data     (gmii_rxd),
    .crc_next (crc_next)
  );

  // End-of-frame verdicts, evaluated on the first dv=0 cycle in DATA
  always_comb begin
    hold_full   = (len >= STAT_LEN_W'(HOLD_D));
    crc_err_now = (crc != CRC_RESIDUE);
    len_err_now = (32'(len) < 32'(MIN_LEN)) || (32'(len) > 32'(MAX_LEN));
    any_err_now = crc_err_now || len_err_now || gmii_err;
  end

  // Framing FSM with registered data/status outputs and statistics counters
  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      state         <= ST_DROP;
      from_reset    <= 1'b1;
      pre_cnt       <= '0;
      crc           <= CRC_INIT;
      len           <= '0;
      gmii_err      <= 1'b0;
      sof_pend      <= 1'b1;
      for (int i = 0; i < HOLD_D; i++) hold[i] <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      data_sof      <= 1'b0;
      data_eof      <= 1'b0;
      stat_valid    <= 1'b0;
      stat_len      <= '0;
      stat_crc_err  <= 1'b0;
      stat_len_err  <= 1'b0;
      stat_gmii_err <= 1'b0;
      cnt_good      <= '0;
      cnt_bad       <= '0;
      cnt_drop      <= '0;
    end else begin
      data_valid <= 1'b0;
      data_sof   <= 1'b0;
      data_eof   <= 1'b0;
      stat_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (gmii_rx_dv) begin
            if (gmii_rxd == PREAMBLE_BYTE) begin
              state   <= ST_PREAMBLE;
              pre_cnt <= PRE_W'(1);
            end else if (gmii_rxd == SFD_BYTE) begin
              state <= ST_DATA;
            end else begin
              state      <= ST_DROP;
              from_reset <= 1'b0;
            end
          end
        end

        ST_PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state <= ST_IDLE;
          end else if (gmii_rx_er) begin
            state      <= ST_DROP;
            from_reset <= 1'b0;
          end else if (gmii_rxd == PREAMBLE_BYTE) begin
            pre_cnt <= pre_cnt + 1'b1;
            if (pre_cnt == PRE_W'(MAX_PREAMBLE)) begin
              state      <= ST_DROP;
              from_reset <= 1'b0;
            end
          end else if (gmii_rxd == SFD_BYTE) begin
            state <= ST_DATA;
          end else begin
            state      <= ST_DROP;
            from_reset <= 1'b0;
          end
        end

        ST_DATA: begin
          if (gmii_rx_dv) begin
            crc <= crc_next;
            len <= len_inc(len);
            if (gmii_rx_er) gmii_err <= 1'b1;
            if (hold_full) begin
              data_out   <= hold[HOLD_D-1];
              data_valid <= 1'b1;
              data_sof   <= sof_pend;
              sof_pend   <= 1'b0;
            end
            for (int i = HOLD_D - 1; i > 0; i--) hold[i] <= hold[i-1];
            hold[0] <= gmii_rxd;
          end else begin
            if (hold_full) begin
              data_out   <= hold[HOLD_D-1];
              data_valid <= 1'b1;
              data_sof   <= sof_pend;
              data_eof   <= 1'b1;
            end
            stat_valid    <= 1'b1;
            stat_len      <= len;
            stat_crc_err  <= crc_err_now;
            stat_len_err  <= len_err_now;
            stat_gmii_err <= gmii_err;
            if (any_err_now) cnt_bad  <= cnt_bad + 1'b1;
            else             cnt_good <= cnt_good + 1'b1;
            crc      <= CRC_INIT;
            len      <= '0;
            gmii_err <= 1'b0;
            sof_pend <= 1'b1;
            state    <= ST_IDLE;
          end
        end

        ST_DROP: begin
          if (!gmii_rx_dv) begin
            state      <= ST_IDLE;
            from_reset <= 1'b0;
            if (!from_reset) cnt_drop <= cnt_drop + 1'b1;
          end
        end

        default: begin
          state <= ST_DROP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Bench for gmii_rx_framer: two instances (FCS stripped / passed through) share
// one GMII stimulus; a table of frames feeds byte and status scoreboards.
module tb_gmii_rx_framer;

  logic        rx_clk = 1'b0;
  logic        reset;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;

  logic [7:0]  s_data_out, p_data_out;
  logic        s_data_valid, p_data_valid, s_data_sof, p_data_sof, s_data_eof, p_data_eof;
  logic        s_stat_valid, p_stat_valid;
  logic [15:0] s_stat_len, p_stat_len;
  logic        s_stat_crc_err, p_stat_crc_err, s_stat_len_err, p_stat_len_err;
  logic        s_stat_gmii_err, p_stat_gmii_err;
  logic [31:0] s_cnt_good, p_cnt_good, s_cnt_bad, p_cnt_bad, s_cnt_drop, p_cnt_drop;

  always #4 rx_clk = ~rx_clk;

  gmii_rx_framer #(.STRIP_FCS(1)) dut_strip (
    .rx_clk(rx_clk), .reset(reset), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er), .data_out(s_data_out), .data_valid(s_data_valid),
    .data_sof(s_data_sof), .data_eof(s_data_eof), .stat_valid(s_stat_valid),
    .stat_len(s_stat_len), .stat_crc_err(s_stat_crc_err), .stat_len_err(s_stat_len_err),
    .stat_gmii_err(s_stat_gmii_err), .cnt_good(s_cnt_good), .cnt_bad(s_cnt_bad),
    .cnt_drop(s_cnt_drop)
  );

  gmii_rx_framer #(.STRIP_FCS(0)) dut_pass (
    .rx_clk(rx_clk), .reset(reset), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er), .data_out(p_data_out), .data_valid(p_data_valid),
    .data_sof(p_data_sof), .data_eof(p_data_eof), .stat_valid(p_stat_valid),
    .stat_len(p_stat_len), .stat_crc_err(p_stat_crc_err), .stat_len_err(p_stat_len_err),
    .stat_gmii_err(p_stat_gmii_err), .cnt_good(p_cnt_good), .cnt_bad(p_cnt_bad),
    .cnt_drop(p_cnt_drop)
  );

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } byte_exp_t;

  typedef struct {
    logic [15:0] len;
    logic        crc;
    logic        lerr;
    logic        gerr;
  } stat_exp_t;

  // One frame of stimulus plus the status it must produce
  typedef struct {
    int n_pre;
    int bad_pre;
    int len;
    int flip_idx;
    int er_idx;
    int gap;
    int exp_drop;
    int exp_crc;
    int exp_lerr;
    int exp_gerr;
  } vec_t;

  byte_exp_t q_s[$];
  byte_exp_t q_p[$];
  stat_exp_t sq_s[$];
  stat_exp_t sq_p[$];

  int n_vec  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  int exp_good = 0, exp_bad = 0, exp_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    gmii_rxd   = d;
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_strip_cnt_good"}, s_cnt_good, exp_good);
    check({tag, "_strip_cnt_bad"},  s_cnt_bad,  exp_bad);
    check({tag, "_strip_cnt_drop"}, s_cnt_drop, exp_drop);
    check({tag, "_pass_cnt_good"},  p_cnt_good, exp_good);
    check({tag, "_pass_cnt_bad"},   p_cnt_bad,  exp_bad);
    check({tag, "_pass_cnt_drop"},  p_cnt_drop, exp_drop);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] fr[$];
    logic [31:0] crc;
    logic [31:0] fcs;
    int nout_s;
    byte_exp_t eb;
    stat_exp_t es;
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < v.len - 4; i++) begin
      fr.push_back(8'($urandom));
      crc = crc_ref(crc, fr[i]);
    end
    fcs = ~crc;
    for (int i = 0; i < 4; i++) fr.push_back(fcs[8*i +: 8]);
    if (v.flip_idx >= 0) fr[v.flip_idx] = fr[v.flip_idx] ^ 8'h01;

    if (v.exp_drop == 0) begin
      nout_s = (v.len >= 5) ? v.len - 4 : 0;
      for (int i = 0; i < nout_s; i++) begin
        eb.d = fr[i]; eb.sof = (i == 0); eb.eof = (i == nout_s - 1);
        q_s.push_back(eb);
      end
      for (int i = 0; i < v.len; i++) begin
        eb.d = fr[i]; eb.sof = (i == 0); eb.eof = (i == v.len - 1);
        q_p.push_back(eb);
      end
      es.len = 16'(v.len); es.crc = v.exp_crc[0]; es.lerr = v.exp_lerr[0]; es.gerr = v.exp_gerr[0];
      sq_s.push_back(es);
      sq_p.push_back(es);
    end

    repeat (v.n_pre) drive(8'h55, 1'b1, 1'b0);
    drive((v.bad_pre != 0) ? 8'h5A : 8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < v.len; i++) drive(fr[i], 1'b1, (i == v.er_idx));
    drive(8'h00, 1'b0, 1'b0);
    check($sformatf("v%0d_strip_stat_pulse", idx), s_stat_valid, (v.exp_drop == 0));
    check($sformatf("v%0d_pass_stat_pulse", idx),  p_stat_valid, (v.exp_drop == 0));
    repeat (v.gap - 1) drive(8'h00, 1'b0, 1'b0);

    if (v.exp_drop != 0) exp_drop++;
    else if ((v.exp_crc | v.exp_lerr | v.exp_gerr) != 0) exp_bad++;
    else exp_good++;
    check_counters($sformatf("v%0d", idx));
  endtask

  // Strip instance: every output byte and status pulse must match the queue head
  always @(negedge rx_clk) begin : mon_strip
    byte_exp_t eb;
    stat_exp_t es;
    if (mon_en) begin
      if (s_data_valid) begin
        if (q_s.size() == 0) check("strip_unexpected_byte", 32'(s_data_out), 32'hFFFF_FFFF);
        else begin
          eb = q_s.pop_front();
          check("strip_data", s_data_out, eb.d);
          check("strip_sof", s_data_sof, eb.sof);
          check("strip_eof", s_data_eof, eb.eof);
        end
      end
      if (s_stat_valid) begin
        if (sq_s.size() == 0) check("strip_unexpected_stat", 1, 0);
        else begin
          es = sq_s.pop_front();
          check("strip_stat_len", s_stat_len, es.len);
          check("strip_stat_crc_err", s_stat_crc_err, es.crc);
          check("strip_stat_len_err", s_stat_len_err, es.lerr);
          check("strip_stat_gmii_err", s_stat_gmii_err, es.gerr);
        end
      end
    end
  end

  // Pass-through instance scoreboard
  always @(negedge rx_clk) begin : mon_pass
    byte_exp_t eb;
    stat_exp_t es;
    if (mon_en) begin
      if (p_data_valid) begin
        if (q_p.size() == 0) check("pass_unexpected_byte", 32'(p_data_out), 32'hFFFF_FFFF);
        else begin
          eb = q_p.pop_front();
          check("pass_data", p_data_out, eb.d);
          check("pass_sof", p_data_sof, eb.sof);
          check("pass_eof", p_data_eof, eb.eof);
        end
      end
      if (p_stat_valid) begin
        if (sq_p.size() == 0) check("pass_unexpected_stat", 1, 0);
        else begin
          es = sq_p.pop_front();
          check("pass_stat_len", p_stat_len, es.len);
          check("pass_stat_crc_err", p_stat_crc_err, es.crc);
          check("pass_stat_len_err", p_stat_len_err, es.lerr);
          check("pass_stat_gmii_err", p_stat_gmii_err, es.gerr);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[15];
    vec_t good;
    //           pre bad len  flip er  gap drop crc lerr gerr
    vecs[0]  = '{7, 0,   64,  -1, -1, 3,  0,   0,  0,   0};
    vecs[1]  = '{7, 0,   64,  10, -1, 3,  0,   1,  0,   0};
    vecs[2]  = '{7, 0,   40,  -1, -1, 3,  0,   0,  1,   0};
    vecs[3]  = '{7, 0, 1523,  -1, -1, 3,  0,   0,  1,   0};
    vecs[4]  = '{7, 0, 1522,  -1, -1, 3,  0,   0,  0,   0};
    vecs[5]  = '{7, 0,   63,  -1, -1, 3,  0,   0,  1,   0};
    vecs[6]  = '{2, 1,   60,  -1, -1, 3,  1,   0,  0,   0};
    vecs[7]  = '{7, 0,   64,  -1, -1, 3,  0,   0,  0,   0};
    vecs[8]  = '{8, 0,   64,  -1, -1, 3,  1,   0,  0,   0};
    vecs[9]  = '{0, 0,   64,  -1, -1, 3,  0,   0,  0,   0};
    vecs[10] = '{1, 0,    5,  -1, -1, 3,  0,   0,  1,   0};
    vecs[11] = '{7, 0,    4,  -1, -1, 3,  0,   0,  1,   0};
    vecs[12] = '{7, 0,   64,  -1, -1, 1,  0,   0,  0,   0};
    vecs[13] = '{7, 0,   64,  -1, 20, 2,  0,   0,  0,   1};
    vecs[14] = '{7, 0,   64,   0,  5, 3,  0,   1,  0,   1};
    good     = '{7, 0,   64,  -1, -1, 3,  0,   0,  0,   0};

    reset      = 1'b1;
    gmii_rxd   = 8'h00;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1;
    check("rst_strip_data_valid", s_data_valid, 0);
    check("rst_strip_stat_valid", s_stat_valid, 0);
    check("rst_strip_data_out", s_data_out, 0);
    check("rst_pass_data_valid", p_data_valid, 0);
    check_counters("rst");
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) drive(8'h00, 1'b0, 1'b0);
    check_counters("post_rst");

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Reset in the middle of a frame, then rx_dv stays high after release
    mon_en = 1'b0;
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    repeat (30) drive(8'($urandom), 1'b1, 1'b0);
    reset = 1'b1;
    repeat (3) drive(8'($urandom), 1'b1, 1'b0);
    check("midrst_strip_data_valid", s_data_valid, 0);
    check("midrst_pass_stat_valid", p_stat_valid, 0);
    exp_good = 0; exp_bad = 0; exp_drop = 0;
    check_counters("midrst");
    reset  = 1'b0;
    mon_en = 1'b1;
    drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    repeat (18) drive(8'($urandom), 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    check_counters("after_rst_dv_fall");
    run_vec(good, 15);

    repeat (3) drive(8'h00, 1'b0, 1'b0);
    check("strip_bytes_drained", q_s.size(), 0);
    check("pass_bytes_drained", q_p.size(), 0);
    check("strip_stats_drained", sq_s.size(), 0);
    check("pass_stats_drained", sq_p.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
